mult_secuencial_param: RTL and testbench

Parametrised sequential shift-and-add multiplier. It is the successor of the fixed 8-bit multiplier FSM and adds four things: a generic operand width, a signed/unsigned mode, a start/done handshake and a result held stable between operations. It sits in the datapath as a multi-cycle arithmetic unit. A controller drives it with start and waits for done.

---
 rtl/mult_secuencial_param.sv | 165 ++++++++++++++++
 tb/tb_mult_secuencial_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_secuencial_param.sv
// -----------------------------------------------------------------------------
// mult_secuencial_param
// Sequential shift-and-add multiplier with a generic operand width, optional
// two's-complement operands, a start/done handshake and a result register that
// only changes when an operation completes.
//
// Ports
//   clk            system clock, everything on the rising edge
//   rst            synchronous active-high reset
//   start          request a multiplication (looked at only in IDLE)
//   signed_mode    1 = operands are two's complement, 0 = unsigned
//   multiplicando  multiplicand, captured with start
//   multiplicador  multiplier, captured with start
//   busy           high in LOAD, ADD, SHIFT and DONE
//   done           one-cycle completion pulse (DONE state)
//   estado         current state: IDLE=000 LOAD=001 ADD=010 SHIFT=011 DONE=100
//   producto       registered 2*WIDTH-bit result
//
// Timing: start seen at edge E0 -> DONE entered at E0+2*WIDTH+1 -> IDLE at
// E0+2*WIDTH+2. Operands are converted to magnitudes in LOAD, the unsigned
// product is formed by WIDTH ADD/SHIFT pairs, and the sign is applied while
// writing producto.
// -----------------------------------------------------------------------------
module mult_secuencial_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicando,
    input  logic [WIDTH-1:0]     multiplicador,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           estado,
    output logic [2*WIDTH-1:0]   producto
);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_ADD   = 3'b010;
    localparam logic [2:0] S_SHIFT = 3'b011;
    localparam logic [2:0] S_DONE  = 3'b100;

    localparam int CW = $clog2(WIDTH);

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;

    logic [WIDTH-1:0]     r_mcand;     // raw operand in IDLE/LOAD, magnitude afterwards
    logic [WIDTH-1:0]     r_mplier;    // multiplier, low half of the shifting product
    logic [WIDTH-1:0]     r_acc;       // upper half of the product
    logic                 r_carry;     // carry out of the last ADD
    logic                 r_neg;
    logic                 r_signed;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_prod;

    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_mcand_mag;
    logic [WIDTH-1:0]     w_mplier_mag;
    logic [2*WIDTH-1:0]   w_shift_prod;

    assign w_last = (r_cnt == CW'(WIDTH - 1));
    assign w_sum  = {1'b0, r_acc} + {1'b0, r_mcand};

    // Negating the most negative value yields 2^(WIDTH-1), which is exactly
    // the magnitude we want when read as unsigned.
    assign w_mcand_mag  = (r_signed && r_mcand[WIDTH-1])  ? -r_mcand  : r_mcand;
    assign w_mplier_mag = (r_signed && r_mplier[WIDTH-1]) ? -r_mplier : r_mplier;

    // Value the product takes after the final shift; used to load producto on
    // the same edge that enters DONE.
    assign w_shift_prod = {r_carry, r_acc, r_mplier[WIDTH-1:1]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_state_next = S_ADD;
            S_ADD:   w_state_next = S_SHIFT;
            S_SHIFT: w_state_next = w_last ? S_DONE : S_ADD;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;   // illegal encodings recover
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_LOAD, S_ADD, S_SHIFT: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign estado   = r_state;
    assign producto = r_prod;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= multiplicando;
                        r_mplier <= multiplicador;
                        r_signed <= signed_mode;
                    end
                end
                S_LOAD: begin
                    r_mcand  <= w_mcand_mag;
                    r_mplier <= w_mplier_mag;
                    r_neg    <= r_signed & (r_mcand[WIDTH-1] ^ r_mplier[WIDTH-1]);
                    r_acc    <= '0;
                    r_carry  <= 1'b0;
                    r_cnt    <= '0;
                end
                S_ADD: begin
                    if (r_mplier[0]) begin
                        {r_carry, r_acc} <= w_sum;
                    end else begin
                        r_carry <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_acc    <= {r_carry, r_acc[WIDTH-1:1]};
                    r_mplier <= {r_acc[0], r_mplier[WIDTH-1:1]};
                    r_carry  <= 1'b0;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_prod <= r_neg ? -w_shift_prod : w_shift_prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_secuencial_param.sv
module tb_mult_secuencial_param;

    logic        clk = 1'b0;
    logic        rst;

    // WIDTH=8 instance
    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [2:0]  est8;
    logic [15:0] p8;

    // WIDTH=4 instance
    logic        start4, sm4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [2:0]  est4;
    logic [7:0]  p4;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] last_p8 = 16'h0;
    logic [7:0]  last_p4 = 8'h0;

    always #5 clk = ~clk;

    mult_secuencial_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplicando(a8), .multiplicador(b8),
        .busy(busy8), .done(done8), .estado(est8), .producto(p8)
    );

    mult_secuencial_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .multiplicando(a4), .multiplicador(b4),
        .busy(busy4), .done(done4), .estado(est4), .producto(p4)
    );

    typedef struct {
        bit          w4;
        bit          sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation on the selected instance, checking the state sequence,
    // latency, hold of the old result, the new result and the return to IDLE.
    task automatic run_op(input bit w4, input bit sm, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp);
        int          w;
        int          lat;
        bit          seen;
        logic [15:0] prev;
        logic [15:0] pr;
        logic [2:0]  est;
        logic [2:0]  exp_est;
        w    = w4 ? 4 : 8;
        lat  = 2 * w + 1;
        seen = 1'b0;
        prev = w4 ? {8'h00, last_p4} : last_p8;
        if (w4) begin
            start4 = 1'b1; sm4 = sm; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        end
        @(posedge clk); #1;  // edge E0
        start4 = 1'b0;
        start8 = 1'b0;
        // operands wiggle while busy; must not matter
        if (w4) begin a4 = ~a4; b4 = ~b4; sm4 = ~sm4; end
        else    begin a8 = ~a8; b8 = ~b8; sm8 = ~sm8; end
        check("estado_load", w4 ? est4 : est8, 3'b001);
        check("busy_load", w4 ? busy4 : busy8, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            est = w4 ? est4 : est8;
            pr  = w4 ? {8'h00, p4} : p8;
            if (k <= lat) begin
                exp_est = (k == lat) ? 3'b100 : ((k % 2 == 1) ? 3'b010 : 3'b011);
                check("estado_seq", est, exp_est);
            end
            if ((w4 ? done4 : done8) == 1'b1) begin
                seen = 1'b1;
                check("latency", k, lat);
                check("producto", pr, exp);
                break;
            end else begin
                check("producto_hold", pr, prev);
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
        end
        @(posedge clk); #1;
        check("estado_idle", w4 ? est4 : est8, 3'b000);
        check("busy_idle", w4 ? busy4 : busy8, 1'b0);
        check("done_single", w4 ? done4 : done8, 1'b0);
        check("producto_after", w4 ? {8'h00, p4} : p8, exp);
        if (w4) last_p4 = exp[7:0];
        else    last_p8 = exp;
        $display("op w%0d sm=%0d %0h x %0h -> %0h (expected %0h)", w, sm, a, b,
                 w4 ? {8'h00, p4} : p8, exp);
    endtask

    initial begin
        int dones;
        int done_k [3];
        logic [15:0] done_p [3];

        vecs[0]  = '{1'b0, 1'b0, 8'd23,  8'd17,  16'h0187};
        vecs[1]  = '{1'b0, 1'b0, 8'd255, 8'd255, 16'hFE01};
        vecs[2]  = '{1'b0, 1'b0, 8'd0,   8'd200, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 8'hFD,  8'h05,  16'hFFF1};
        vecs[4]  = '{1'b0, 1'b1, 8'h80,  8'h80,  16'h4000};
        vecs[5]  = '{1'b0, 1'b1, 8'h7F,  8'h80,  16'hC080};
        vecs[6]  = '{1'b0, 1'b0, 8'hFD,  8'h05,  16'h04F1};
        vecs[7]  = '{1'b0, 1'b1, 8'h05,  8'hFD,  16'hFFF1};
        vecs[8]  = '{1'b0, 1'b1, 8'hFF,  8'hFF,  16'h0001};
        vecs[9]  = '{1'b0, 1'b1, 8'h00,  8'h80,  16'h0000};
        vecs[10] = '{1'b1, 1'b0, 8'h0F,  8'h0F,  16'h00E1};
        vecs[11] = '{1'b1, 1'b1, 8'h08,  8'h07,  16'h00C8};
        vecs[12] = '{1'b1, 1'b1, 8'h08,  8'h08,  16'h0040};
        vecs[13] = '{1'b1, 1'b1, 8'h03,  8'h0F,  16'h00FD};
        vecs[14] = '{1'b1, 1'b0, 8'h0C,  8'h0B,  16'h0084};

        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = 8'h0; b8 = 8'h0;
        start4 = 1'b0; sm4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_estado8", est8, 3'b000);
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_prod8", p8, 16'h0000);
        check("rst_estado4", est4, 3'b000);
        check("rst_prod4", p4, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].w4, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Handshake: start held high, operands changed mid-operation
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd23; b8 = 8'd17;
        dones = 0;
        @(posedge clk); #1;  // E0
        for (int k = 1; k <= 80 && dones < 3; k++) begin
            @(posedge clk); #1;
            if (k == 5)  begin a8 = 8'd3; b8 = 8'd3; end
            if (k == 20) begin a8 = 8'd5; b8 = 8'd5; end
            if (k == 39) start8 = 1'b0;
            if (done8) begin
                done_k[dones] = k;
                done_p[dones] = p8;
                dones++;
            end
        end
        check("hs_done_count", dones, 3);
        if (dones == 3) begin
            check("hs_done1_at", done_k[0], 17);
            check("hs_prod1", done_p[0], 16'd391);
            check("hs_done2_at", done_k[1], 36);
            check("hs_prod2", done_p[1], 16'd9);
            check("hs_done3_at", done_k[2], 55);
            check("hs_prod3", done_p[2], 16'd25);
        end
        $display("handshake: %0d done pulses", dones);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("hs_idle", est8, 3'b000);
        last_p8 = 16'd25;

        // Reset in the middle of an operation
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd23; b8 = 8'd17;
        @(posedge clk); #1;  // E0
        start8 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
        end
        check("mid_estado_shift", est8, 3'b011);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_estado", est8, 3'b000);
        check("midrst_prod", p8, 16'h0000);
        check("midrst_busy", busy8, 1'b0);
        begin
            int spurious;
            spurious = 0;
            for (int k = 0; k < 25; k++) begin
                if (done8) spurious++;
                @(posedge clk); #1;
            end
            check("midrst_no_done", spurious, 0);
        end
        $display("reset mid-operation: estado=%0d producto=%0h", est8, p8);
        last_p8 = 16'h0000;
        run_op(1'b0, 1'b0, 8'd23, 8'd17, 16'h0187);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
